// File: rtl/tpu_accum_pkg.sv
// Shared accumulator-table constants, sequencer state encoding and the
// write-address function used by every accumulator-table client.
package tpu_accum_pkg;

  localparam int DEF_MAX_OUT_ROWS = 128;
  localparam int DEF_MAX_OUT_COLS = 128;
  localparam int DEF_SYS_ARR_ROWS = 16;
  localparam int DEF_SYS_ARR_COLS = 16;

  localparam int NUM_ACCUM_ROWS = DEF_MAX_OUT_ROWS * DEF_MAX_OUT_COLS / DEF_SYS_ARR_COLS;
  localparam int NUM_SUBMATS_M  = DEF_MAX_OUT_ROWS / DEF_SYS_ARR_ROWS;
  localparam int NUM_SUBMATS_N  = DEF_MAX_OUT_COLS / DEF_SYS_ARR_COLS;
  localparam int ADDR_W         = $clog2(NUM_ACCUM_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // Rows leave the array bottom-first, so beat cnt lands on row (rows-1-cnt).
  function automatic int unsigned accum_addr(input int unsigned n, input int unsigned m,
                                             input int unsigned cnt,
                                             input int unsigned out_rows,
                                             input int unsigned arr_rows);
    return n * out_rows + m * arr_rows + (arr_rows - 1 - cnt);
  endfunction

endpackage

// File: rtl/accum_addr_pipe.sv
// Per-column skew pipeline: column j sees {wr_en, wr_accum, addr} j cycles
// after column 0; every stage resets to zero.
module accum_addr_pipe #(
  parameter int COLS   = 16,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_en,
  input  logic                   in_accum,
  input  logic [ADDR_W-1:0]      in_addr,
  output logic [COLS-1:0]        wr_en,
  output logic [COLS-1:0]        wr_accum,
  output logic [COLS*ADDR_W-1:0] wr_addr
);

  logic [COLS-1:0]             vld_pipe;
  logic [COLS-1:0]             acc_pipe;
  logic [COLS-1:0][ADDR_W-1:0] addr_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      acc_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= in_en;
      acc_pipe[0]  <= in_accum;
      addr_pipe[0] <= in_addr;
      for (int j = 1; j < COLS; j++) begin
        vld_pipe[j]  <= vld_pipe[j-1];
        acc_pipe[j]  <= acc_pipe[j-1];
        addr_pipe[j] <= addr_pipe[j-1];
      end
    end
  end

  assign wr_en    = vld_pipe;
  assign wr_accum = acc_pipe;
  assign wr_addr  = addr_pipe;

endmodule

// File: rtl/accum_table_sequencer.sv
// Accumulator-table write sequencer for a tiled matmul drain.
// Optional sticky protocol-error flag: define ACCUM_TABLE_SEQ_ERR_EN.
module accum_table_sequencer
  import tpu_accum_pkg::*;
#(
  parameter int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
  parameter int MAX_OUT_COLS = DEF_MAX_OUT_COLS,
  parameter int SYS_ARR_ROWS = DEF_SYS_ARR_ROWS,
  parameter int SYS_ARR_COLS = DEF_SYS_ARR_COLS
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [$clog2(MAX_OUT_ROWS/SYS_ARR_ROWS)-1:0] cfg_last_m,
  input  logic [$clog2(MAX_OUT_COLS/SYS_ARR_COLS)-1:0] cfg_last_n,
  input  logic cfg_accum,
  input  logic out_valid,
  output logic busy,
  output logic done,
  output logic [SYS_ARR_COLS-1:0] wr_en,
  output logic [SYS_ARR_COLS*$clog2(MAX_OUT_ROWS*MAX_OUT_COLS/SYS_ARR_COLS)-1:0] wr_addr,
  output logic [SYS_ARR_COLS-1:0] wr_accum
`ifdef ACCUM_TABLE_SEQ_ERR_EN
  ,
  output logic err
`endif
);

  localparam int ADDR_BITS = $clog2(MAX_OUT_ROWS * MAX_OUT_COLS / SYS_ARR_COLS);
  localparam int M_W       = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS);
  localparam int N_W       = $clog2(MAX_OUT_COLS / SYS_ARR_COLS);
  localparam int CNT_W     = $clog2(SYS_ARR_ROWS);
  localparam int DRN_W     = $clog2(SYS_ARR_COLS);

  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [M_W-1:0]       m_q, last_m_q;
  logic [N_W-1:0]       n_q, last_n_q;
  logic [DRN_W-1:0]     drain_q;
  logic                 accum_q;
  logic                 done_q;
  logic                 start_ok, beat, last_beat, drain_end;
  logic [ADDR_BITS-1:0] beat_addr;

  assign beat      = (state_q == ST_RUN) && out_valid;
  assign last_beat = beat && (cnt_q == CNT_W'(SYS_ARR_ROWS-1)) &&
                     (m_q == last_m_q) && (n_q == last_n_q);
  assign drain_end = (state_q == ST_DRAIN) && (drain_q == DRN_W'(SYS_ARR_COLS-1));
  assign beat_addr = ADDR_BITS'(accum_addr(32'(n_q), 32'(m_q), 32'(cnt_q),
                                           MAX_OUT_ROWS, SYS_ARR_ROWS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A start landing on the done cycle is dropped; IDLE accepts from the next cycle.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          start_ok = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN:   if (last_beat) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      m_q      <= '0;
      n_q      <= '0;
      last_m_q <= '0;
      last_n_q <= '0;
      accum_q  <= 1'b0;
      drain_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q  <= drain_end;
      drain_q <= (state_q == ST_DRAIN) ? drain_q + 1'b1 : '0;
      if (start_ok) begin
        cnt_q    <= '0;
        m_q      <= '0;
        n_q      <= '0;
        last_m_q <= cfg_last_m;
        last_n_q <= cfg_last_n;
        accum_q  <= cfg_accum;
      end else if (beat) begin
        if (cnt_q == CNT_W'(SYS_ARR_ROWS-1)) begin
          cnt_q <= '0;
          if (m_q == last_m_q) begin
            m_q <= '0;
            n_q <= (n_q == last_n_q) ? '0 : n_q + 1'b1;
          end else begin
            m_q <= m_q + 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef ACCUM_TABLE_SEQ_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                        err <= 1'b0;
    else if (start_ok)                                                err <= 1'b0;
    else if ((out_valid && state_q != ST_RUN) || (start && state_q != ST_IDLE)) err <= 1'b1;
  end
`endif

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  accum_addr_pipe #(
    .COLS   (SYS_ARR_COLS),
    .ADDR_W (ADDR_BITS)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_en    (beat),
    .in_accum (beat & accum_q),
    .in_addr  (beat ? beat_addr : '0),
    .wr_en    (wr_en),
    .wr_accum (wr_accum),
    .wr_addr  (wr_addr)
  );

endmodule

// File: tb/tb_accum_table_sequencer.sv
// Directed bench for accum_table_sequencer: address order, skew, drain/done,
// bubbles, async reset abort and (when enabled) the error flag.
module tb_accum_table_sequencer;

  localparam int COLS = 16;
  localparam int AW   = 10;

  logic             clk = 1'b0;
  logic             reset, start, cfg_accum, out_valid;
  logic [2:0]       cfg_last_m, cfg_last_n;
  logic             busy, done;
  logic [COLS-1:0]  wr_en, wr_accum;
  logic [COLS*AW-1:0] wr_addr;
`ifdef ACCUM_TABLE_SEQ_ERR_EN
  logic             err;
`endif

  accum_table_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_last_m (cfg_last_m),
    .cfg_last_n (cfg_last_n),
    .cfg_accum  (cfg_accum),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_accum   (wr_accum)
`ifdef ACCUM_TABLE_SEQ_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int wcnt [COLS];
  int acc15, first0, last15, done_cnt, done_cyc, c0_175, c5_175;

  always @(posedge clk) cyc++;

  // Bookkeeping of observed writes, sampled mid-cycle.
  always @(negedge clk) begin
    for (int j = 0; j < COLS; j++) if (wr_en[j]) wcnt[j]++;
    if (wr_en[0] && first0 < 0) first0 = cyc;
    if (wr_en[COLS-1]) last15 = cyc;
    if (wr_en[COLS-1] && wr_accum[COLS-1]) acc15++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (wr_en[0] && wr_addr[0 +: AW] == 10'd175) c0_175 = cyc;
    if (wr_en[5] && wr_addr[5*AW +: AW] == 10'd175) c5_175 = cyc;
  end

  function automatic logic [AW-1:0] col_addr(input int j);
    return wr_addr[j*AW +: AW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task clr_mon;
    for (int j = 0; j < COLS; j++) wcnt[j] = 0;
    acc15 = 0; first0 = -1; last15 = -1; done_cnt = 0; done_cyc = -1;
    c0_175 = -1; c5_175 = -1;
  endtask

  task do_start(input logic [2:0] lm, input logic [2:0] ln, input logic acc);
    cfg_last_m = lm; cfg_last_n = ln; cfg_accum = acc;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task wait_done(input string tag);
    for (int k = 0; k < 300 && !done; k++) tick;
    chk({tag, "_done_seen"}, done, 1);
  endtask

  task feed(input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      out_valid = 1'b1;
      tick;
    end
    out_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_valid = 1'b0;
    cfg_last_m = '0; cfg_last_n = '0; cfg_accum = 1'b0;
    clr_mon;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_accum", wr_accum, 0);
    chk("rst_wr_addr_any", |wr_addr, 0);
    reset = 1'b0;
    tick;

    // Single sub-matrix, back-to-back beats.
    clr_mon;
    do_start(3'd0, 3'd0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      out_valid = 1'b1;
      tick;
      chk("t1_en0", wr_en[0], 1);
      chk("t1_addr0", col_addr(0), 64'(15 - k));
    end
    out_valid = 1'b0;
    wait_done("t1");
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t1_start_on_done_ignored", busy, 0);
    chk("t1_done_one_cycle", done, 0);
    chk("t1_col15_span", 64'(last15 - first0), 30);
    chk("t1_done_after_col15", 64'(done_cyc - last15), 1);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_col15_writes", wcnt[15], 16);
    chk("t1_accum_off", acc15, 0);

    // Full 2x2 run with accumulate.
    clr_mon;
    do_start(3'd1, 3'd1, 1'b1);
    for (int k = 0; k < 64; k++) begin
      out_valid = 1'b1;
      tick;
      if (k == 0)  chk("t2_accum0", wr_accum[0], 1);
      if (k == 16) chk("t2_addr_beat16", col_addr(0), 31);
      if (k == 32) chk("t2_addr_beat32", col_addr(0), 143);
      if (k == 63) chk("t2_addr_last", col_addr(0), 144);
    end
    out_valid = 1'b0;
    wait_done("t2");
    tick;
    chk("t2_col0_writes", wcnt[0], 64);
    chk("t2_col15_writes", wcnt[15], 64);
    chk("t2_col15_accum", acc15, 64);
    chk("t2_done_count", done_cnt, 1);

    // Spot check n=1,m=2,cnt=0 -> 175, skewed 5 cycles to column 5.
    clr_mon;
    do_start(3'd2, 3'd1, 1'b0);
    feed(96);
    wait_done("t3");
    tick;
    chk("t3_col0_175_seen", c0_175 >= 0, 1);
    chk("t3_col5_skew", 64'(c5_175 - c0_175), 5);
    chk("t3_col5_writes", wcnt[5], 96);

    // Alternating out_valid: bubbles on every column.
    clr_mon;
    do_start(3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      out_valid = (i % 2 == 0);
      tick;
      chk("t4_en0", wr_en[0], 64'(i % 2 == 0));
      if (i % 2 == 0) chk("t4_addr0", col_addr(0), 64'(15 - i / 2));
      if (i == 20) chk("t4_en_even_cols", wr_en, 64'h5555);
      if (i == 21) chk("t4_en_odd_cols", wr_en, 64'hAAAA);
    end
    out_valid = 1'b0;
    wait_done("t4");
    tick;
    chk("t4_col7_writes", wcnt[7], 16);

    // Async reset mid-run at beat 7.
    clr_mon;
    do_start(3'd0, 3'd0, 1'b0);
    feed(7);
    out_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_wr_en", wr_en, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_addr_any", |wr_addr, 0);
    out_valid = 1'b0;
    tick;
    reset = 1'b0;
    repeat (40) tick;
    chk("t5_no_done", done_cnt, 0);
    do_start(3'd0, 3'd0, 1'b0);
    out_valid = 1'b1;
    tick;
    out_valid = 1'b0;
    chk("t5_restart_addr", col_addr(0), 15);
    feed(15);
    wait_done("t5");
    tick;

`ifdef ACCUM_TABLE_SEQ_ERR_EN
    clr_mon;
    chk("t6_err_clear", err, 0);
    out_valid = 1'b1;
    tick;
    out_valid = 1'b0;
    chk("t6_idle_valid_ignored", busy, 0);
    chk("t6_err_idle_valid", err, 1);
    do_start(3'd0, 3'd0, 1'b0);
    chk("t6_err_cleared_by_start", err, 0);
    feed(3);
    out_valid = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t6_err_start_busy", err, 1);
    chk("t6_run_unaffected", col_addr(0), 12);
    feed(12);
    wait_done("t6");
    tick;
    chk("t6_col0_writes", wcnt[0], 16);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/accum_table_sequencer.md
Name: accum_table_sequencer

Overview:
- Sequences writes into the accumulator table while the systolic array drains a divide-and-conquer matrix multiply.
- Tracks the output-row count within a sub-matrix and the sub-matrix position (m, n), and forms the write address.
- Skews the address and write enable across the accumulator columns through a one-cycle-per-column pipeline.
- Sits between the top-level TPU control (start/config) and the accumulator table column write ports.

Parameters:
- MAX_OUT_ROWS, 128: max rows of the output matrix.
- MAX_OUT_COLS, 128: max cols of the output matrix.
- SYS_ARR_ROWS, 16: systolic array rows; number of output beats per sub-matrix.
- SYS_ARR_COLS, 16: systolic array cols; number of accumulator columns and pipeline depth.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE only.
- cfg_last_m  in  clog2(MAX_OUT_ROWS/SYS_ARR_ROWS)  last sub-matrix row index (count-1); sampled with start.
- cfg_last_n  in  clog2(MAX_OUT_COLS/SYS_ARR_COLS)  last sub-matrix col index; sampled with start.
- cfg_accum  in  1  1 = add into table, 0 = overwrite; sampled with start.
- out_valid  in  1  array column 0 presents a valid output row this cycle.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at run completion.
- wr_en  out  SYS_ARR_COLS  per-column write enable.
- wr_addr  out  SYS_ARR_COLS*ADDR_W  per-column addresses concatenated, column 0 in LSBs; ADDR_W = clog2(MAX_OUT_ROWS*MAX_OUT_COLS/SYS_ARR_COLS).
- wr_accum  out  SYS_ARR_COLS  per-column accumulate flag travelling with wr_en.

Behaviour:
- Reset: all outputs 0; state IDLE; counters (cnt, m, n) 0; pipeline cleared. Reset mid-run aborts the run immediately. No done pulse.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start: latch the config, clear counters.
  - RUN -> DRAIN on the accepted beat with cnt==SYS_ARR_ROWS-1, m==cfg_last_m, n==cfg_last_n.
  - DRAIN -> IDLE after SYS_ARR_COLS cycles, with done=1 in the IDLE-entry cycle.
- Beat accept: out_valid in RUN only. out_valid in IDLE/DRAIN is ignored, and so is start while busy.
- Counter order:
  - cnt increments per accepted beat and wraps at SYS_ARR_ROWS-1.
  - On cnt wrap, m increments. m wraps at cfg_last_m, and the wrap increments n.
  - cnt, m and n never exceed their configured last values.
- Address for an accepted beat: n*MAX_OUT_ROWS + m*SYS_ARR_ROWS + (SYS_ARR_ROWS-1-cnt), computed ADDR_W wide with no truncation of valid combinations. Rows arrive bottom-first.
- Latency:
  - Beat accepted at cycle t -> wr_en[0], wr_addr[0], wr_accum[0] valid at t+1.
  - Column j gets the same triple at t+1+j (a shift by one register per column).
- Gaps: out_valid may deassert for any number of cycles in RUN. Counters hold, and bubbles propagate down the pipeline as wr_en=0.
- Back-to-back: one beat per cycle is sustained with no stall.
- The pipeline keeps shifting in DRAIN; the last beat is written by column SYS_ARR_COLS-1 in the final DRAIN cycle.
- start coincident with done (IDLE-entry cycle) is ignored; start is accepted from the next cycle.
- cfg_last_m = cfg_last_n = 0: a single sub-matrix of SYS_ARR_ROWS beats.

Optional Feature:
- Macro: ACCUM_TABLE_SEQ_ERR_EN.
- Defined:
  - Adds output err (1 bit, sticky, cleared only by reset or by an accepted start).
  - Set by out_valid in IDLE or DRAIN, or by start while busy.
- Undefined: no err port; those events are silently ignored as above.

Decomposition:
- Package tpu_accum_pkg holds:
  - localparams NUM_ACCUM_ROWS, NUM_SUBMATS_M, NUM_SUBMATS_N, ADDR_W;
  - the state enum (IDLE/RUN/DRAIN);
  - the address-compute function shared with other accumulator-table logic.
- Sub-module accum_addr_pipe: SYS_ARR_COLS-stage shift register of {wr_en, wr_accum, addr}, reset to 0.

Test Plan:
- Single sub-matrix (cfg_last_m=0, cfg_last_n=0, cfg_accum=0), 16 back-to-back beats.
  - wr_addr[0] = 15..0 on cycles t+1..t+16; wr_en[15] last asserted at t+31.
  - done pulses once, then busy=0.
- Full run (cfg_last_m=1, cfg_last_n=1):
  - beat 16 -> addr 31; beat 32 -> addr 143; final beat -> addr 144.
  - exactly 64 writes per column.
- Spot check: beat with n=1, m=2, cnt=0 gives addr 175, appearing on column 5 five cycles after column 0.
- out_valid toggling 1/0 every cycle: counters advance only on 1-cycles, and wr_en shows alternating bubbles on every column.
- reset asserted mid-RUN at beat 7: outputs 0 asynchronously, no done. A new start then begins at addr 15.
- Error conditions (with ACCUM_TABLE_SEQ_ERR_EN): out_valid in IDLE sets err; start while busy is ignored and sets err; both leave the run unaffected.
